// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Registered ALU execute stage with a two-entry (output + skid) buffer
//   feeding the memory stage over a valid/ready handshake.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module alu_exec_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_alucontrol,
  input  logic [WIDTH-1:0]   in_srca,
  input  logic [WIDTH-1:0]   in_srcb,
  input  logic [WIDTH-1:0]   in_writedata,
  input  logic [WIDTH-1:0]   in_pcbranch,
  input  logic [REGADDR-1:0] in_writereg,
  input  logic               in_regwrite,
  input  logic               in_memwrite,
  input  logic               in_memtoreg,
  input  logic               in_branch,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_aluout,
  output logic               out_zero,
  output logic               out_overflow,
  output logic               out_illegal,
  output logic               out_pcsrc,
  output logic [WIDTH-1:0]   out_pcbranch,
  output logic [WIDTH-1:0]   out_writedata,
  output logic [REGADDR-1:0] out_writereg,
  output logic               out_regwrite,
  output logic               out_memwrite,
  output logic               out_memtoreg
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0]   aluout;
    logic               zero;
    logic               overflow;
    logic               illegal;
    logic               pcsrc;
    logic [WIDTH-1:0]   pcbranch;
    logic [WIDTH-1:0]   writedata;
    logic [REGADDR-1:0] writereg;
    logic               regwrite;
    logic               memwrite;
    logic               memtoreg;
  } beat_t;

  // ---------------------------------------------------------------------------
  // ALU on the incoming beat; the whole result is registered as one beat.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_sum;
  logic [WIDTH-1:0] alu_diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  beat_t            in_beat;

  assign alu_sum  = in_srca + in_srcb;
  assign alu_diff = in_srca - in_srcb;
  assign add_ovf  = (in_srca[WIDTH-1] == in_srcb[WIDTH-1]) &
                    (alu_sum[WIDTH-1] != in_srca[WIDTH-1]);
  assign sub_ovf  = (in_srca[WIDTH-1] != in_srcb[WIDTH-1]) &
                    (alu_diff[WIDTH-1] != in_srca[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (in_alucontrol)
      ALU_AND: alu_res = in_srca & in_srcb;
      ALU_OR:  alu_res = in_srca | in_srcb;
      ALU_ADD: begin
        alu_res = alu_sum;
        alu_ovf = add_ovf;
      end
      ALU_SUB: begin
        alu_res = alu_diff;
        alu_ovf = sub_ovf;
      end
      // Signed less-than: the true sign of a-b is the raw sign corrected by overflow.
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, alu_diff[WIDTH-1] ^ sub_ovf};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    in_beat           = '0;
    in_beat.aluout    = alu_res;
    in_beat.zero      = (alu_res == '0);
    in_beat.overflow  = alu_ovf;
    in_beat.illegal   = alu_ill;
    in_beat.pcsrc     = in_branch & (alu_res == '0);
    in_beat.pcbranch  = in_pcbranch;
    in_beat.writedata = in_writedata;
    in_beat.writereg  = in_writereg;
    in_beat.regwrite  = in_regwrite;
    in_beat.memwrite  = in_memwrite;
    in_beat.memtoreg  = in_memtoreg;
  end

  // ---------------------------------------------------------------------------
  // Output register + skid register
  // ---------------------------------------------------------------------------
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  beat_t out_q, out_d;
  beat_t skid_q, skid_d;
  logic  accept;
  logic  out_free;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = in_beat;
        end
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output is stalled: park the beat, in_ready falls next cycle.
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_aluout    = out_q.aluout;
  assign out_zero      = out_q.zero;
  assign out_overflow  = out_q.overflow;
  assign out_illegal   = out_q.illegal;
  assign out_pcsrc     = out_q.pcsrc;
  assign out_pcbranch  = out_q.pcbranch;
  assign out_writedata = out_q.writedata;
  assign out_writereg  = out_q.writereg;
  assign out_regwrite  = out_q.regwrite;
  assign out_memwrite  = out_q.memwrite;
  assign out_memtoreg  = out_q.memtoreg;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//   Directed and randomized checks of alu_exec_stage against a queue model.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_alucontrol;
  logic [31:0] in_srca, in_srcb, in_writedata, in_pcbranch;
  logic [4:0]  in_writereg;
  logic        in_regwrite, in_memwrite, in_memtoreg, in_branch;
  logic        out_valid, out_ready;
  logic [31:0] out_aluout, out_pcbranch, out_writedata;
  logic        out_zero, out_overflow, out_illegal, out_pcsrc;
  logic [4:0]  out_writereg;
  logic        out_regwrite, out_memwrite, out_memtoreg;

  alu_exec_stage #(.WIDTH(32), .REGADDR(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alucontrol(in_alucontrol),
    .in_srca(in_srca), .in_srcb(in_srcb), .in_writedata(in_writedata),
    .in_pcbranch(in_pcbranch), .in_writereg(in_writereg),
    .in_regwrite(in_regwrite), .in_memwrite(in_memwrite),
    .in_memtoreg(in_memtoreg), .in_branch(in_branch),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluout(out_aluout),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_illegal(out_illegal),
    .out_pcsrc(out_pcsrc), .out_pcbranch(out_pcbranch),
    .out_writedata(out_writedata), .out_writereg(out_writereg),
    .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
    .out_memtoreg(out_memtoreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] aluout;
    logic [3:0]  flags;   // {zero, overflow, illegal, pcsrc}
    logic [71:0] pass;    // {pcbranch, writedata, writereg, regwrite, memwrite, memtoreg}
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference ALU: true signed arithmetic in 64 bits, overflow = out of 32-bit range.
  function automatic exp_t ref_beat();
    exp_t   e;
    longint sa, sb, r;
    logic   ovf, ill;
    sa  = longint'($signed(in_srca));
    sb  = longint'($signed(in_srcb));
    r   = 0;
    ovf = 1'b0;
    ill = 1'b0;
    case (in_alucontrol)
      3'b000: r = longint'(in_srca & in_srcb);
      3'b001: r = longint'(in_srca | in_srcb);
      3'b010: begin r = sa + sb; ovf = (r > SMAX) || (r < SMIN); end
      3'b110: begin r = sa - sb; ovf = (r > SMAX) || (r < SMIN); end
      3'b111: r = (sa < sb) ? 1 : 0;
      default: ill = 1'b1;
    endcase
    e.aluout = r[31:0];
    e.flags  = {e.aluout == 32'd0, ovf, ill, in_branch && (e.aluout == 32'd0)};
    e.pass   = {in_pcbranch, in_writedata, in_writereg, in_regwrite, in_memwrite, in_memtoreg};
    return e;
  endfunction

  task automatic model_edge();
    bit rdy;
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      rdy = (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back(ref_beat());
    end
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0 && out_valid) begin
      check("aluout", out_aluout, q[0].aluout);
      check("flags", {out_zero, out_overflow, out_illegal, out_pcsrc}, q[0].flags);
      check("passthru", {out_pcbranch, out_writedata, out_writereg, out_regwrite,
                         out_memwrite, out_memtoreg}, q[0].pass);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                      input logic br, input logic [31:0] pcb);
    in_valid      = 1'b1;
    in_alucontrol = ctl;
    in_srca       = a;
    in_srcb       = b;
    in_branch     = br;
    in_pcbranch   = pcb;
    in_writedata  = $urandom;
    in_writereg   = 5'($urandom);
    in_regwrite   = 1'($urandom);
    in_memwrite   = 1'($urandom);
    in_memtoreg   = 1'($urandom);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_alucontrol = '0; in_srca = '0; in_srcb = '0;
    in_writedata = '0; in_pcbranch = '0; in_writereg = '0;
    in_regwrite = 1'b0; in_memwrite = 1'b0; in_memtoreg = 1'b0; in_branch = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_data", {out_aluout, out_pcbranch, out_writedata, out_writereg},
          {32'd0, 32'd0, 32'd0, 5'd0});
    check("rst_flags", {out_zero, out_overflow, out_illegal, out_pcsrc, out_regwrite,
                        out_memwrite, out_memtoreg}, 7'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU corner cases, back-to-back with out_ready high.
    out_ready = 1'b1;
    send(3'b010, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h0); step();
    check("add_ovf", {out_aluout, out_overflow, out_zero}, {32'h80000000, 1'b1, 1'b0});
    send(3'b111, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0); step();
    check("slt_neg", {out_aluout, out_overflow}, {32'h1, 1'b0});
    send(3'b111, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0); step();
    check("slt_swap", {out_aluout, out_zero}, {32'h0, 1'b1});
    send(3'b110, 32'd5, 32'd5, 1'b1, 32'h00400020); step();
    check("beq_taken", {out_aluout, out_zero, out_pcsrc, out_pcbranch},
          {32'h0, 1'b1, 1'b1, 32'h00400020});
    send(3'b110, 32'd5, 32'd6, 1'b1, 32'h00400020); step();
    check("beq_not", out_pcsrc, 1'b0);
    send(3'b100, 32'h1234, 32'h5678, 1'b0, 32'h0); step();
    check("illegal", {out_illegal, out_aluout}, {1'b1, 32'h0});
    in_valid = 1'b0; step();

    // Backpressure: A, B, C with the output stalled.
    out_ready = 1'b0;
    send(3'b010, 32'h100, 32'h0, 1'b0, 32'h0); step();
    check("bp_A_hold", {out_aluout, in_ready}, {32'h100, 1'b1});
    send(3'b010, 32'h200, 32'h0, 1'b0, 32'h0); step();
    check("bp_B_skid", {out_aluout, in_ready}, {32'h100, 1'b0});
    send(3'b010, 32'h300, 32'h0, 1'b0, 32'h0); step();
    check("bp_C_held", {out_aluout, in_ready}, {32'h100, 1'b0});
    out_ready = 1'b1; step();
    check("bp_B_out", {out_valid, out_aluout}, {1'b1, 32'h200});
    step();
    check("bp_C_out", {out_valid, out_aluout}, {1'b1, 32'h300});
    in_valid = 1'b0; step();
    check("bp_empty", out_valid, 1'b0);

    // Flush with both entries full and a beat offered.
    out_ready = 1'b0;
    send(3'b001, 32'hA, 32'h0, 1'b0, 32'h0); step();
    send(3'b001, 32'hB, 32'h0, 1'b0, 32'h0); step();
    send(3'b001, 32'hC, 32'h0, 1'b0, 32'h0); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush", {out_valid, in_ready}, 2'b01);
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("flush_gone", out_valid, 1'b0);
    end

    // Asynchronous reset while a beat is held.
    out_ready = 1'b0;
    send(3'b010, 32'h55, 32'h1, 1'b0, 32'h0); step();
    in_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    q.delete();
    check("arst_clear", {out_valid, in_ready, out_aluout}, {1'b0, 1'b1, 32'h0});
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(3'b010, 32'h10, 32'h20, 1'b0, 32'h0); step();
    check("arst_first", {out_valid, out_aluout}, {1'b1, 32'h30});
    in_valid = 1'b0; step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 7)
        send(3'($urandom), rand_operand(), rand_operand(), 1'($urandom), $urandom);
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
